multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 80 ++++++++
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/mc_out_decode.sv | 64 ++++++
 rtl/multicycle_control.sv | 84 ++++++++
 tb/tb_multicycle_control.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: types and constants shared by the multicycle controller and the datapath.
//   state_e    - controller state codes (debug-visible on the state port)
//   OP_*       - supported instruction opcodes
//   aluop_e    - ALU operation select (add / subtract / use funct field)
//   alusrcb_e  - ALU B-operand select
//   pcsource_e - next-PC source select
//   ctrl_t     - bundle of all datapath control signals
//   op_target  - first execution state for an opcode (S_FETCH when unsupported)
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsource_e;

  typedef struct packed {
    logic      pc_write;
    logic      pc_write_cond;
    logic      i_or_d;
    logic      mem_read;
    logic      mem_write;
    logic      mem_to_reg;
    logic      ir_write;
    logic      reg_dst;
    logic      reg_write;
    logic      alu_src_a;
    alusrcb_e  alu_src_b;
    aluop_e    alu_op;
    pcsource_e pc_source;
  } ctrl_t;

  // Where DECODE goes for a given opcode; S_FETCH marks an unsupported opcode.
  function automatic state_e op_target(input logic [5:0] op);
    case (op)
      OP_R:         return S_EXEC;
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
      OP_ADDI:      return S_ADDI_EXEC;
      default:      return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath signal bundle.
//   op, mem_ready          - datapath to controller (opcode, memory completion)
//   PCWrite .. ALUSrcA     - 1-bit datapath controls
//   ALUSrcB, ALUOp, PCSource - 2-bit selects
//   state, illegal_op, retired - debug/status
// Modports: master = controller side, slave = datapath side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             IRWrite;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, illegal_op, retired
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, illegal_op, retired
  );

endinterface

// File: rtl/mc_out_decode.sv
// mc_out_decode: Moore output decode for the multicycle controller.
//   i_state     - current controller state
//   i_mem_ready - memory completion; only gates IRWrite/PCWrite in FETCH
//   o_ctrl      - all datapath controls; anything not named for a state is 0
module mc_out_decode
  import mc_pkg::*;
(
  input  state_e i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    // NOTE: defaulting the whole bundle first keeps every path assigned, so no latch is inferred.
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        // The instruction is only captured, and PC+4 only committed, once memory delivers it.
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: o_ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-subset control FSM.
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   bus   - master side of multicycle_control_if (op/mem_ready in; datapath
//           controls, state, sticky illegal_op and retired counter out)
// Supports R-type, lw, sw, beq, j, addi; any other opcode returns to FETCH
// and sets illegal_op, which holds until reset.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_e           r_state;
  logic             r_illegal_op;
  logic [CNT_W-1:0] r_retired;
  ctrl_t            w_ctrl;
  logic             w_run;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_illegal_op <= 1'b0;
      r_retired    <= '0;
    end else begin
      case (r_state)
        S_FETCH:     if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= op_target(bus.op);
          if (op_target(bus.op) == S_FETCH) r_illegal_op <= 1'b1;
        end
        S_MEM_ADDR:  r_state <= (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (bus.mem_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE: begin
          if (bus.mem_ready) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNT_W'(1);
          end
        end
        S_EXEC:      r_state <= S_R_WB;
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
        // Final state of every legal instruction: it retires on the way back to FETCH.
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  mc_out_decode u_out_decode (
    .i_state     (r_state),
    .i_mem_ready (bus.mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Reset is combinationally folded into the strobes so that asserting it kills
  // any write in the same cycle, and FETCH's MemRead/IRWrite stay quiet while held.
  assign w_run = reset;

  assign bus.PCWrite     = w_ctrl.pc_write      & w_run;
  assign bus.PCWriteCond = w_ctrl.pc_write_cond & w_run;
  assign bus.MemRead     = w_ctrl.mem_read      & w_run;
  assign bus.MemWrite    = w_ctrl.mem_write     & w_run;
  assign bus.IRWrite     = w_ctrl.ir_write      & w_run;
  assign bus.RegWrite    = w_ctrl.reg_write     & w_run;
  assign bus.IorD        = w_ctrl.i_or_d;
  assign bus.MemtoReg    = w_ctrl.mem_to_reg;
  assign bus.RegDst      = w_ctrl.reg_dst;
  assign bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.ALUOp       = w_ctrl.alu_op;
  assign bus.PCSource    = w_ctrl.pc_source;
  assign bus.state       = r_state;
  assign bus.illegal_op  = r_illegal_op;
  assign bus.retired     = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: drives two controllers (CNT_W=32 and CNT_W=4) with the
// same directed instruction stream and compares every cycle against an
// instruction-level model (expected state sequence per instruction, expected
// control values per state, retired/illegal bookkeeping).
module tb_multicycle_control;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
  localparam int EX = 6, RWB = 7, BR = 8, JP = 9, AE = 10, AW = 11;

  localparam logic [5:0] C_R = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011;
  localparam logic [5:0] C_BEQ = 6'b000100, C_J = 6'b000010, C_ADDI = 6'b001000;
  localparam logic [5:0] C_BAD = 6'b111111;

  typedef struct {
    int st;
    bit mr;
    int ret;
    bit ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mem_ready = 1'b1;
  logic [5:0] op = '0;

  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_ret = 0;
  bit   exp_ill = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus32 ();
  multicycle_control_if #(.CNT_W(4))  bus4 ();

  assign bus32.op        = op;
  assign bus32.mem_ready = mem_ready;
  assign bus4.op         = op;
  assign bus4.mem_ready  = mem_ready;

  multicycle_control #(.CNT_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.master));
  multicycle_control #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4.master));

  logic [15:0] act_ctrl;
  assign act_ctrl = {bus32.PCWrite, bus32.PCWriteCond, bus32.IorD, bus32.MemRead,
                     bus32.MemWrite, bus32.MemtoReg, bus32.IRWrite, bus32.RegDst,
                     bus32.RegWrite, bus32.ALUSrcA, bus32.ALUSrcB, bus32.ALUOp,
                     bus32.PCSource};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Control values each state must present, straight from the state table.
  function automatic logic [15:0] exp_ctrl(input int st, input bit mr);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0;
    logic irw = 0, rdst = 0, rwr = 0, srca = 0;
    logic [1:0] srcb = 2'b00, aop = 2'b00, pcs = 2'b00;
    case (st)
      F:       begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      D:       srcb = 2'b11;
      MA, AE:  begin srca = 1; srcb = 2'b10; end
      MR:      begin mrd = 1; iord = 1; end
      MW:      begin mwr = 1; iord = 1; end
      MWB:     begin rwr = 1; m2r = 1; end
      EX:      begin srca = 1; aop = 2'b10; end
      RWB:     begin rwr = 1; rdst = 1; end
      AW:      rwr = 1;
      BR:      begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      JP:      begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, srca, srcb, aop, pcs};
  endfunction

  // Single compare process: one expected entry per modelled cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("state(exp %0d)", e.st), 32'(bus32.state), 32'(e.st));
      check($sformatf("ctrl(st %0d mr %0d)", e.st, e.mr), 32'(act_ctrl), 32'(exp_ctrl(e.st, e.mr)));
      check("retired32", bus32.retired, 32'(e.ret));
      check("retired4", 32'(bus4.retired), 32'(e.ret % 16));
      check("illegal_op", 32'(bus32.illegal_op), 32'(e.ill));
      check("state4", 32'(bus4.state), 32'(e.st));
    end
  end

  task automatic cyc(input int st, input bit mr);
    exp_t e;
    @(posedge clk);
    #1;
    mem_ready = mr;
    e.st  = st;
    e.mr  = mr;
    e.ret = exp_ret;
    e.ill = exp_ill;
    q.push_back(e);
  endtask

  // Park the controller in FETCH with memory not ready.
  task automatic idle();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  // One instruction: the state sequence follows from the opcode and the stall counts.
  task automatic run(input logic [5:0] opc, input int fstall, input int mstall);
    bit legal = 1'b1;
    op = opc;
    repeat (fstall) cyc(F, 1'b0);
    cyc(F, 1'b1);
    cyc(D, 1'b1);
    case (opc)
      C_R:    begin cyc(EX, 1'b1); cyc(RWB, 1'b1); end
      C_LW:   begin cyc(MA, 1'b1); repeat (mstall) cyc(MR, 1'b0); cyc(MR, 1'b1); cyc(MWB, 1'b1); end
      C_SW:   begin cyc(MA, 1'b1); repeat (mstall) cyc(MW, 1'b0); cyc(MW, 1'b1); end
      C_BEQ:  cyc(BR, 1'b1);
      C_J:    cyc(JP, 1'b1);
      C_ADDI: begin cyc(AE, 1'b1); cyc(AW, 1'b1); end
      default: legal = 1'b0;
    endcase
    if (legal) exp_ret++;
    else exp_ill = 1'b1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with mem_ready high: strobes must stay low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(bus32.state), 0);
    check("rst_retired", bus32.retired, 0);
    check("rst_illegal", 32'(bus32.illegal_op), 0);
    check("rst_strobes", {26'd0, bus32.PCWrite, bus32.PCWriteCond, bus32.IRWrite,
                          bus32.MemRead, bus32.MemWrite, bus32.RegWrite}, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;

    run(C_R, 0, 0);
    check("ret_after_r", bus32.retired, 32'd1);
    run(C_LW, 0, 2);
    check("ret_after_lw", bus32.retired, 32'd2);
    run(C_R, 3, 0);
    check("ret_after_fetch_stall", bus32.retired, 32'd3);
    run(C_BEQ, 0, 0);
    run(C_J, 0, 0);
    run(C_ADDI, 0, 0);
    run(C_SW, 0, 1);
    check("ret_after_mix", bus32.retired, 32'd7);
    run(C_BAD, 0, 0);
    check("illegal_set", 32'(bus32.illegal_op), 32'd1);
    check("ret_after_illegal", bus32.retired, 32'd7);
    run(C_J, 0, 0);
    check("illegal_held", 32'(bus32.illegal_op), 32'd1);
    check("ret_after_j", bus32.retired, 32'd8);

    // Abort a store in MEM_WRITE with an asynchronous reset pulse.
    op = C_SW;
    cyc(F, 1'b1);
    cyc(D, 1'b1);
    cyc(MA, 1'b1);
    cyc(MW, 1'b0);
    @(negedge clk);
    #1;
    check("mw_before_abort", 32'(bus32.MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    check("mw_abort", 32'(bus32.MemWrite), 32'd0);
    check("abort_state", 32'(bus32.state), 32'd0);
    check("abort_retired", bus32.retired, 32'd0);
    check("abort_illegal", 32'(bus32.illegal_op), 32'd0);
    exp_ret = 0;
    exp_ill = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Narrow counter wraps after sixteen retirements.
    repeat (15) run(C_BEQ, 0, 0);
    check("ret4_at_15", 32'(bus4.retired), 32'd15);
    run(C_BEQ, 0, 0);
    check("ret4_wrap", 32'(bus4.retired), 32'd0);
    check("ret32_16", bus32.retired, 32'd16);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
